// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/restoring_divider_uc.sv
// Control unit of the restoring divider: sequences load, shift/subtract pairs and the done pulse.
// Latency: 2*WIDTH+1 cycles from accepted start to done (1 cycle for a zero divisor).
// Backpressure: none; start is only honoured in IDLE, otherwise ignored.
module restoring_divider_uc
    import divider_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div_zero,
    input  logic cnt_last,
    output logic a_clr,
    output logic ld,
    output logic shift_en,
    output logic sub_en,
    output logic cnt_ld,
    output logic cnt_dec,
    output logic done,
    output logic busy
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_clr     = 1'b0;
        ld        = 1'b0;
        shift_en  = 1'b0;
        sub_en    = 1'b0;
        cnt_ld    = 1'b0;
        cnt_dec   = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    a_clr     = 1'b1;
                    ld        = 1'b1;
                    cnt_ld    = 1'b1;
                    state_nxt = div_zero ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift_en  = 1'b1;
                state_nxt = SUB;
            end
            SUB: begin
                sub_en    = 1'b1;
                cnt_dec   = 1'b1;
                state_nxt = cnt_last ? DONE : SHIFT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider (shift-subtract) producing quotient and remainder.
// Latency: done in the cycle after edge 2*WIDTH following the accepted start; zero divisor in 1 cycle.
// Backpressure: start ignored while busy or in the done cycle; results held until the next accepted start.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;

    logic a_clr, ld, shift_en, sub_en, cnt_ld, cnt_dec;
    logic div_zero, cnt_last, sub_ok;
    logic [WIDTH+1:0] diff;

    assign div_zero = (divisor == '0);
    assign cnt_last = (cnt == CW'(1));

    // A is WIDTH+1 bits, so one extra bit of headroom exposes the borrow as the sign
    assign diff   = {1'b0, a_reg} - {2'b00, m_reg};
    assign sub_ok = ~diff[WIDTH+1];

    restoring_divider_uc u_uc (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .div_zero (div_zero),
        .cnt_last (cnt_last),
        .a_clr    (a_clr),
        .ld       (ld),
        .shift_en (shift_en),
        .sub_en   (sub_en),
        .cnt_ld   (cnt_ld),
        .cnt_dec  (cnt_dec),
        .done     (done),
        .busy     (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
        end else begin
            if (a_clr) begin
                a_reg <= '0;
            end else if (shift_en) begin
                a_reg <= {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
            end else if (sub_en && sub_ok) begin
                a_reg <= diff[WIDTH:0];
            end

            if (ld) begin
                q_reg <= dividend;
            end else if (shift_en) begin
                q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end else if (sub_en) begin
                q_reg <= {q_reg[WIDTH-1:1], sub_ok};
            end

            if (ld) begin
                m_reg <= divisor;
            end

            if (cnt_ld) begin
                cnt <= CW'(WIDTH);
            end else if (cnt_dec) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Results are captured on the edge that enters DONE so they are stable for the whole done cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ld) begin
            div_by_zero <= div_zero;
            if (div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (sub_en && cnt_last) begin
            quotient  <= {q_reg[WIDTH-1:1], sub_ok};
            remainder <= sub_ok ? diff[WIDTH-1:0] : a_reg[WIDTH-1:0];
        end
    end

endmodule
